// File: rtl/irq_responder_if.sv
// ---------------------------------------------------------------------------
// irq_responder_if
// Bundles the interrupt-controller and handler-engine signals seen by
// irq_responder.
//   irq_in / irq_id_in         : level request and pending id from controller
//   handler_valid / handler_id : dispatch request towards the handler engine
//   handler_ready              : handler accepts the dispatch
//   handler_done               : handler finished servicing (1-cycle pulse)
//   ack_valid / irq_ack        : acknowledge phase and id back to controller
// Modports:
//   master : the responder (drives dispatch and acknowledge)
//   slave  : the environment (controller + handler engine)
// ---------------------------------------------------------------------------
interface irq_responder_if #(
  parameter int ID_W = 3
) ();
  logic            irq_in;
  logic [ID_W-1:0] irq_id_in;
  logic            handler_valid;
  logic [ID_W-1:0] handler_id;
  logic            handler_ready;
  logic            handler_done;
  logic            ack_valid;
  logic [ID_W-1:0] irq_ack;

  modport master (
    input  irq_in, irq_id_in, handler_ready, handler_done,
    output handler_valid, handler_id, ack_valid, irq_ack
  );

  modport slave (
    output irq_in, irq_id_in, handler_ready, handler_done,
    input  handler_valid, handler_id, ack_valid, irq_ack
  );
endinterface

// File: rtl/irq_responder.sv
// ---------------------------------------------------------------------------
// irq_responder
// Service-side partner of the NPU interrupt controller. Captures a pending
// interrupt id, dispatches it to a handler engine (valid/ready), waits for
// handler completion, then presents the id on the acknowledge bus for
// ACK_HOLD cycles so the controller can release the request. Dispatch +
// service and the release wait are both supervised by a timeout.
// Ports:
//   clk            : clock
//   rst_n          : synchronous active-low reset
//   enable         : allows acceptance of new requests (IDLE only)
//   bus            : irq_responder_if.master (request, dispatch, acknowledge)
//   err_clear      : clears timeout_err (a coincident new timeout wins)
//   busy           : registered, high whenever the FSM is not IDLE
//   timeout_err    : sticky timeout flag
//   err_id         : id of the interrupt that last timed out
//   serviced_count : interrupts completed without timeout, saturating
// ---------------------------------------------------------------------------
module irq_responder #(
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ACK_HOLD       = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  irq_responder_if.master   bus,
  input  logic              err_clear,
  output logic              busy,
  output logic              timeout_err,
  output logic [ID_W-1:0]   err_id,
  output logic [CNT_W-1:0]  serviced_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(ACK_HOLD + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACK_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_SERVICE,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [HW-1:0]   hold;
  logic [ID_W-1:0] id_q;
  logic            handler_valid_q;
  logic            ack_valid_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The captured id doubles as the dispatched id; it is only loaded in IDLE.
  assign bus.handler_valid = handler_valid_q;
  assign bus.handler_id    = id_q;
  assign bus.ack_valid     = ack_valid_q;
  // Outside the ack phase, present the complement of the pending id so the
  // controller can never see a spurious match and release early.
  assign bus.irq_ack       = ack_valid_q ? id_q : ~bus.irq_id_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      tmr             <= '0;
      hold            <= '0;
      id_q            <= '0;
      handler_valid_q <= 1'b0;
      ack_valid_q     <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      err_id          <= '0;
      serviced_count  <= '0;
    end else begin
      // A timeout assignment further down overrides this clear.
      if (err_clear) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable && bus.irq_in) begin
            id_q            <= bus.irq_id_in;
            tmr             <= '0;
            handler_valid_q <= 1'b1;
            busy            <= 1'b1;
            state           <= S_DISPATCH;
          end
        end

        // One timer spans dispatch and service. Completion beats expiry;
        // in DISPATCH expiry beats a late handler_ready.
        S_DISPATCH, S_SERVICE: begin
          if (state == S_SERVICE && bus.handler_done) begin
            serviced_count <= sat_inc(serviced_count);
            hold           <= '0;
            ack_valid_q    <= 1'b1;
            state          <= S_ACK;
          end else if (tmr == TMO_LAST) begin
            timeout_err     <= 1'b1;
            err_id          <= id_q;
            handler_valid_q <= 1'b0;
            hold            <= '0;
            ack_valid_q     <= 1'b1;
            state           <= S_ACK;
          end else begin
            tmr <= tmr + TW'(1);
            if (state == S_DISPATCH && bus.handler_ready) begin
              handler_valid_q <= 1'b0;
              state           <= S_SERVICE;
            end
          end
        end

        S_ACK: begin
          if (hold == HOLD_LAST) begin
            ack_valid_q <= 1'b0;
            tmr         <= '0;
            state       <= S_RELEASE;
          end else begin
            hold <= hold + HW'(1);
          end
        end

        // Wait for the controller to drop the level request.
        S_RELEASE: begin
          if (!bus.irq_in) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (tmr == TMO_LAST) begin
            timeout_err <= 1'b1;
            err_id      <= id_q;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        default: begin
          handler_valid_q <= 1'b0;
          ack_valid_q     <= 1'b0;
          busy            <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_responder.sv
// ---------------------------------------------------------------------------
// tb_irq_responder
// Two responders share one stimulus stream: dut0 with default parameters
// (long timeout, 16-bit counter) and dut1 with TIMEOUT_CYCLES=16, CNT_W=2.
// A timestamp-based reference model predicts every output of both on every
// cycle; directed sequences add literal expectations before a randomized run.
// ---------------------------------------------------------------------------
module tb_irq_responder;

  localparam int P_IDLE = 0, P_DISP = 1, P_SERV = 2, P_ACK = 3, P_REL = 4;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, err_clear;
  logic       irq_in, handler_ready, handler_done;
  logic [2:0] irq_id_in;

  logic       busy0, te0, busy1, te1;
  logic [2:0] eid0, eid1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  irq_responder_if #(.ID_W(3)) if0 ();
  irq_responder_if #(.ID_W(3)) if1 ();

  assign if0.irq_in        = irq_in;
  assign if0.irq_id_in     = irq_id_in;
  assign if0.handler_ready = handler_ready;
  assign if0.handler_done  = handler_done;
  assign if1.irq_in        = irq_in;
  assign if1.irq_id_in     = irq_id_in;
  assign if1.handler_ready = handler_ready;
  assign if1.handler_done  = handler_done;

  irq_responder #(.ID_W(3), .TIMEOUT_CYCLES(1024), .ACK_HOLD(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(if0.master),
    .err_clear(err_clear), .busy(busy0), .timeout_err(te0), .err_id(eid0),
    .serviced_count(cnt0)
  );

  irq_responder #(.ID_W(3), .TIMEOUT_CYCLES(16), .ACK_HOLD(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(if1.master),
    .err_clear(err_clear), .busy(busy1), .timeout_err(te1), .err_id(eid1),
    .serviced_count(cnt1)
  );

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         tmo [2]  = '{1024, 16};
  int         cmax[2]  = '{65535, 3};
  int         cyc      = 0;
  int         ph[2]    = '{P_IDLE, P_IDLE};
  int         t_start[2] = '{0, 0};
  logic [2:0] mid[2]   = '{3'd0, 3'd0};
  logic       merr[2]  = '{1'b0, 1'b0};
  logic [2:0] merrid[2] = '{3'd0, 3'd0};
  int         mcnt[2]  = '{0, 0};

  // t_start marks the edge on which the current phase was entered; all
  // deadlines are expressed as elapsed edges since then.
  task automatic model_step(input int i);
    int   el;
    logic set_err;
    el = cyc - t_start[i];
    set_err = 1'b0;
    if (!rst_n) begin
      ph[i] = P_IDLE; mid[i] = 3'd0; merr[i] = 1'b0; merrid[i] = 3'd0;
      mcnt[i] = 0; t_start[i] = cyc;
    end else begin
      case (ph[i])
        P_IDLE: if (enable && irq_in) begin
          mid[i] = irq_id_in; ph[i] = P_DISP; t_start[i] = cyc;
        end
        P_DISP, P_SERV: begin
          if (ph[i] == P_SERV && handler_done) begin
            mcnt[i] = (mcnt[i] + 1 > cmax[i]) ? cmax[i] : mcnt[i] + 1;
            ph[i] = P_ACK; t_start[i] = cyc;
          end else if (el == tmo[i]) begin
            set_err = 1'b1; ph[i] = P_ACK; t_start[i] = cyc;
          end else if (ph[i] == P_DISP && handler_ready) begin
            ph[i] = P_SERV;
          end
        end
        P_ACK: if (el == HOLD) begin
          ph[i] = P_REL; t_start[i] = cyc;
        end
        default: begin
          if (!irq_in) ph[i] = P_IDLE;
          else if (el == tmo[i]) begin set_err = 1'b1; ph[i] = P_IDLE; end
        end
      endcase
      if (err_clear) merr[i] = 1'b0;
      if (set_err) begin merr[i] = 1'b1; merrid[i] = mid[i]; end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  // ---------------- per-cycle comparison ----------------
  task automatic cmp_inst(input int i, input logic hv, input logic [2:0] hid,
                          input logic av, input logic [2:0] ack, input logic bz,
                          input logic te, input logic [2:0] eid, input logic [15:0] cnt);
    logic [2:0] exp_ack;
    exp_ack = (ph[i] == P_ACK) ? mid[i] : ~irq_id_in;
    chk($sformatf("d%0d_handler_valid", i), hv, (ph[i] == P_DISP));
    if (ph[i] == P_DISP) chk($sformatf("d%0d_handler_id", i), hid, mid[i]);
    chk($sformatf("d%0d_ack_valid", i), av, (ph[i] == P_ACK));
    chk($sformatf("d%0d_irq_ack", i), ack, exp_ack);
    chk($sformatf("d%0d_busy", i), bz, (ph[i] != P_IDLE));
    chk($sformatf("d%0d_timeout_err", i), te, merr[i]);
    chk($sformatf("d%0d_err_id", i), eid, merrid[i]);
    chk($sformatf("d%0d_count", i), cnt, mcnt[i]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, if0.handler_valid, if0.handler_id, if0.ack_valid, if0.irq_ack,
               busy0, te0, eid0, cnt0);
      cmp_inst(1, if1.handler_valid, if1.handler_id, if1.ack_valid, if1.irq_ack,
               busy1, te1, eid1, {14'd0, cnt1});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic serve_one(input logic [2:0] v);
    irq_in = 1'b1; irq_id_in = v;
    step();
    handler_ready = 1'b1;
    step();
    handler_ready = 1'b0; handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    step(); step();
    irq_in = 1'b0;
    step(); step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; err_clear = 1'b0; irq_in = 1'b0;
    irq_id_in = 3'd0; handler_ready = 1'b0; handler_done = 1'b0;
    repeat (3) step();

    // reset state
    chk("rst_hv", if0.handler_valid, 0);
    chk("rst_ack_valid", if0.ack_valid, 0);
    chk("rst_irq_ack", if0.irq_ack, 3'd7);
    chk("rst_busy", busy0, 0);
    chk("rst_count", cnt0, 0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    step();

    // basic service, id 5
    enable = 1'b1; irq_in = 1'b1; irq_id_in = 3'd5;
    step();
    chk("basic_hv_c1", if0.handler_valid, 1);
    chk("basic_hid_c1", if0.handler_id, 5);
    step();
    chk("basic_hv_c2", if0.handler_valid, 1);
    handler_ready = 1'b1;
    step();
    handler_ready = 1'b0;
    chk("basic_hv_drop", if0.handler_valid, 0);
    chk("basic_busy", busy0, 1);
    step(); step(); step();
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    chk("basic_ack_c7", if0.ack_valid, 1);
    chk("basic_irq_ack_c7", if0.irq_ack, 5);
    step();
    chk("basic_ack_c8", if0.ack_valid, 1);
    chk("basic_irq_ack_c8", if0.irq_ack, 5);
    step();
    chk("basic_ack_end", if0.ack_valid, 0);
    chk("basic_count", cnt0, 1);
    chk("basic_busy_rel", busy0, 1);
    irq_in = 1'b0;
    step();
    chk("basic_busy_idle", busy0, 0);

    // idle acknowledge safety
    for (int v = 0; v < 8; v++) begin
      logic [2:0] inv;
      irq_id_in = 3'(v);
      inv = ~irq_id_in;
      #1;
      chk("idle_ack_valid", if0.ack_valid, 0);
      chk("idle_irq_ack", if0.irq_ack, inv);
      step();
    end

    // backpressure on dut0; dut1 times out in DISPATCH
    irq_id_in = 3'd2; irq_in = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      chk("bp_hv", if0.handler_valid, 1);
      chk("bp_hid", if0.handler_id, 2);
      chk("bp_no_tmo", te0, 0);
      step();
    end
    handler_ready = 1'b1;
    step();
    handler_ready = 1'b0; handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    step(); step();
    irq_in = 1'b0;
    step(); step();
    chk("bp_d1_tmo", te1, 1);
    chk("bp_d1_errid", eid1, 2);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("bp_d1_clear", te1, 0);

    // service timeout on dut1, id 3
    irq_id_in = 3'd3; irq_in = 1'b1;
    step();
    handler_ready = 1'b1;
    step();
    handler_ready = 1'b0;
    repeat (14) step();
    chk("tmo_before", te1, 0);
    step();
    chk("tmo_err", te1, 1);
    chk("tmo_errid", eid1, 3);
    chk("tmo_ack_valid", if1.ack_valid, 1);
    chk("tmo_irq_ack", if1.irq_ack, 3);
    chk("tmo_count_held", cnt1, 1);
    irq_in = 1'b0;
    step(); step(); step();
    chk("tmo_d1_idle", busy1, 0);
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    step(); step(); step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("tmo_clear", te1, 0);

    // done coincident with the last timeout cycle
    irq_id_in = 3'd6; irq_in = 1'b1;
    step();
    handler_ready = 1'b1;
    step();
    handler_ready = 1'b0;
    repeat (14) step();
    handler_done = 1'b1;
    step();
    handler_done = 1'b0;
    chk("coinc_no_err", te1, 0);
    chk("coinc_ack", if1.ack_valid, 1);
    chk("coinc_count_d1", cnt1, 2);
    chk("coinc_count_d0", cnt0, 4);
    step(); step();
    irq_in = 1'b0;
    step(); step();

    // enable low keeps IDLE
    enable = 1'b0; irq_in = 1'b1; irq_id_in = 3'd4;
    repeat (5) step();
    chk("en0_busy0", busy0, 0);
    chk("en0_busy1", busy1, 0);
    chk("en0_hv", if0.handler_valid, 0);
    irq_in = 1'b0; enable = 1'b1;
    step();

    // reset during SERVICE
    irq_id_in = 3'd7; irq_in = 1'b1;
    step();
    handler_ready = 1'b1;
    step();
    handler_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rstsvc_busy0", busy0, 0);
    chk("rstsvc_busy1", busy1, 0);
    chk("rstsvc_hid", if0.handler_id, 0);
    chk("rstsvc_count0", cnt0, 0);
    chk("rstsvc_errid1", eid1, 0);
    rst_n = 1'b1; irq_in = 1'b0;
    step();

    // saturation of the 2-bit counter
    for (int n = 1; n <= 5; n++) begin
      serve_one(3'(n));
      chk("sat_count_d1", cnt1, (n < 3) ? n : 3);
      chk("sat_count_d0", cnt0, n);
    end
    chk("sat_model", mcnt[1], 3);

    // randomized run
    for (int k = 0; k < 3000; k++) begin
      rst_n         = ($urandom_range(0, 399) != 0);
      enable        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) irq_in = ~irq_in;
      if ($urandom_range(0, 3) == 0) irq_id_in = 3'($urandom);
      handler_ready = 1'($urandom_range(0, 1));
      handler_done  = ($urandom_range(0, 5) == 0);
      err_clear     = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_responder.md
Name: irq_responder

Overview:
- Service-side counterpart of the NPU interrupt controller.
- Consumes the controller's interrupt request and id, dispatches the id to a handler engine over a valid/ready handshake, and waits for handler completion.
- Then drives the acknowledge id back so the controller releases the request.
- Provides timeout supervision, a sticky error flag and a saturating serviced-interrupt counter.

Parameters:
ID_W, 3, width of interrupt id / acknowledge bus
TIMEOUT_CYCLES, 1024, max cycles from DISPATCH entry to handler_done; also max cycles in RELEASE
ACK_HOLD, 2, cycles ack_valid/irq_ack are held (min 1)
CNT_W, 16, width of serviced_count

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
enable  input  1  allows acceptance of new requests
irq_in  input  1  interrupt request from controller (level)
irq_id_in  input  ID_W  id of pending interrupt
handler_valid  output  1  dispatch request to handler
handler_id  output  ID_W  id being dispatched
handler_ready  input  1  handler accepts dispatch
handler_done  input  1  handler finished servicing (1-cycle pulse)
ack_valid  output  1  acknowledge phase active
irq_ack  output  ID_W  acknowledge id to controller
busy  output  1  FSM not in IDLE
timeout_err  output  1  sticky timeout flag
err_id  output  ID_W  id that last timed out
err_clear  input  1  clears timeout_err
serviced_count  output  CNT_W  interrupts completed without timeout, saturating

Behaviour:
- Interface: one clock, clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - handler_valid = 0, handler_id = 0, ack_valid = 0.
  - timeout_err = 0, err_id = 0, serviced_count = 0, busy = 0.
  - Timeout counter = 0, captured id id_q = 0.
- irq_ack:
  - When ack_valid = 1: irq_ack = id_q.
  - Otherwise irq_ack = ~irq_id_in (combinational), so it never matches the controller's pending id.
- States:
  - IDLE:
    - If enable and irq_in are sampled high at edge N: id_q <= irq_id_in, state <= DISPATCH.
    - handler_valid = 1 and handler_id = id_q from cycle N+1.
  - DISPATCH:
    - Hold handler_valid and handler_id stable until handler_ready = 1. On that edge, handler_valid <= 0 and state <= SERVICE.
    - handler_done is ignored in this state.
  - SERVICE:
    - Wait for handler_done. On done: state <= ACK and serviced_count increments, saturating at all ones.
  - ACK:
    - ack_valid = 1 for exactly ACK_HOLD cycles, then state <= RELEASE.
  - RELEASE:
    - Wait until irq_in = 0, then state <= IDLE.
    - A re-asserted irq_in is accepted only after returning to IDLE, minimum one IDLE cycle.
- Timeout:
  - The counter clears on DISPATCH entry and increments every cycle in DISPATCH/SERVICE.
  - At count TIMEOUT_CYCLES-1 without handler_done: timeout_err <= 1, err_id <= id_q, handler_valid <= 0, state <= ACK. serviced_count does not increment.
  - The counter clears again on RELEASE entry. If irq_in is still high at TIMEOUT_CYCLES-1: timeout_err <= 1, err_id <= id_q, state <= IDLE.
- Simultaneous events:
  - handler_done and the timeout expiry in the same cycle: done wins, no error.
  - err_clear and a new timeout in the same cycle: the set wins.
- enable only gates IDLE entry. Deasserting it mid-operation does not abort the in-flight interrupt.
- irq_in dropping before ACK does not abort the sequence; the full service and ACK still complete.
- Reset asserted in any state returns all state and outputs to their reset values on the next edge.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Basic service: enable=1, irq_in=1, irq_id_in=5 at edge 0; handler_ready at cycle 2; handler_done at cycle 6; irq_in drops after ack.
  - handler_valid/handler_id=5 at cycles 1–2.
  - ack_valid=1 with irq_ack=5 for 2 cycles from cycle 7.
  - serviced_count=1; busy=0 after irq_in falls.
- Idle ack safety: irq_in=0, irq_id_in sweeps 0..7 → ack_valid=0 and irq_ack = ~irq_id_in every cycle.
- Backpressure: handler_ready held low 20 cycles with TIMEOUT_CYCLES=1024 → handler_valid and handler_id stable for the full 20 cycles; no timeout.
- Service timeout: TIMEOUT_CYCLES=16, id 3, handler never sends done.
  - timeout_err=1, err_id=3 after 16 cycles in DISPATCH/SERVICE.
  - ACK still issued; serviced_count unchanged.
  - err_clear pulse → timeout_err=0.
- Boundary cases:
  - handler_done coincident with the final timeout cycle → no error, count increments.
  - enable=0 with irq_in=1 → stays IDLE.
  - rst_n low during SERVICE → next edge all outputs at reset values.
- Saturation: CNT_W=2, service 5 interrupts → serviced_count goes 1, 2, 3, 3, 3.
